// File: rtl/add16_nibble_seq.sv
// add16_nibble_seq: W-bit adder sequenced one nibble per cycle
// through an external 4-bit ripple adder, valid/ready on both sides.
module add16_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic [3:0]           nib_a,
  output logic [3:0]           nib_b,
  output logic                 nib_cin,
  input  logic [3:0]           nib_sum,
  input  logic                 nib_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   sum_reg;
  logic [IW-1:0]  idx;
  logic           carry_reg;
  logic           cout_reg;
  logic           last;

  assign last = (idx == IW'(NIBBLES - 1));
  assign sum  = sum_reg;
  assign cout = cout_reg;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    nib_a     = 4'd0;
    nib_b     = 4'd0;
    nib_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx == IW'(i)) begin
            nib_a = a_reg[4*i+:4];
            nib_b = b_reg[4*i+:4];
          end
        end
        // carry only ever comes from the register, never from nib_cout
        nib_cin = carry_reg;
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            idx       <= '0;
            carry_reg <= cin;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) sum_reg[4*i+:4] <= nib_sum;
          end
          carry_reg <= nib_cout;
          idx       <= idx + 1'b1;
          if (last) cout_reg <= nib_cout;
        end
        default: ;
      endcase
    end
  end

endmodule
